// File: rtl/tx_queue_pkg.sv
// Shared encodings and defaults for the light-link transmit queue.
// Optional statistics counters are enabled with the TX_QUEUE_STATS_EN macro.
package tx_queue_pkg;

    localparam int TXQ_PACKET_WIDTH = 8;
    localparam int TXQ_DEPTH        = 8;
    localparam int TXQ_PTR_WIDTH    = 3;

    typedef enum logic [1:0] {
        TXQ_IDLE    = 2'd0,
        TXQ_SEND    = 2'd1,
        TXQ_RELEASE = 2'd2
    } txq_state_e;

    typedef enum logic {
        TXQ_CLASS_PRIO = 1'b0,
        TXQ_CLASS_NORM = 1'b1
    } txq_class_e;

    function automatic logic [15:0] txq_sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/tx_queue_sync_fifo.sv
// Circular-buffer FIFO used for each traffic class of tx_queue.
// A write while full is accepted only when a pop frees the slot in the same cycle.
module tx_queue_sync_fifo #(
    parameter int PACKET_WIDTH = 8,
    parameter int DEPTH        = 8,
    parameter int PTR_WIDTH    = 3
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    wr_en_i,
    input  logic [PACKET_WIDTH-1:0] wr_data_i,
    input  logic                    rd_en_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [PACKET_WIDTH-1:0] head_o
);

    logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH:0]      wr_ptr_q;
    logic [PTR_WIDTH:0]      rd_ptr_q;
    logic [PTR_WIDTH:0]      wr_ptr_d;
    logic [PTR_WIDTH:0]      rd_ptr_d;
    logic                    full_q;
    logic                    empty_q;
    logic                    full_d;
    logic                    empty_d;
    logic                    push_s;
    logic                    pop_s;

    // Next pointers and flags; the extra pointer MSB separates full from empty.
    always_comb begin
        pop_s    = rd_en_i & ~empty_q;
        push_s   = wr_en_i & (~full_q | pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{PTR_WIDTH{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{PTR_WIDTH{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]) &&
                  (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]);
    end

    // Pointer and flag registers.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= {(PTR_WIDTH+1){1'b0}};
            rd_ptr_q <= {(PTR_WIDTH+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wr_data_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

endmodule

// File: rtl/tx_queue.sv
// Two-class transmit queue feeding the priority/normal arbiter and byte transmitter.
// Define TX_QUEUE_STATS_EN to add saturating drop/sent counters.
module tx_queue
    import tx_queue_pkg::*;
#(
    parameter int PACKET_WIDTH = TXQ_PACKET_WIDTH,
    parameter int DEPTH        = TXQ_DEPTH,
    parameter int PTR_WIDTH    = TXQ_PTR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    prio_wr_en,
    input  logic [PACKET_WIDTH-1:0] prio_wr_data,
    output logic                    prio_full,
    input  logic                    norm_wr_en,
    input  logic [PACKET_WIDTH-1:0] norm_wr_data,
    output logic                    norm_full,
    output logic                    req_priority,
    output logic                    req_normal,
    input  logic                    grant_priority,
    input  logic                    grant_normal,
    output logic                    tx_enable,
    output logic [PACKET_WIDTH-1:0] tx_data,
    input  logic                    tx_done
`ifdef TX_QUEUE_STATS_EN
   ,output logic [15:0]             prio_drop_count,
    output logic [15:0]             norm_drop_count,
    output logic [15:0]             sent_count
`endif
);

    txq_state_e              state_q;
    txq_class_e              class_q;
    logic                    req_prio_q;
    logic                    req_norm_q;
    logic                    tx_enable_q;
    logic [PACKET_WIDTH-1:0] tx_data_q;
    logic                    prio_pop_s;
    logic                    norm_pop_s;
    logic                    prio_empty_s;
    logic                    norm_empty_s;
    logic [PACKET_WIDTH-1:0] prio_head_s;
    logic [PACKET_WIDTH-1:0] norm_head_s;

    tx_queue_sync_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH),
        .PTR_WIDTH    (PTR_WIDTH)
    ) u_prio_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .wr_en_i   (prio_wr_en),
        .wr_data_i (prio_wr_data),
        .rd_en_i   (prio_pop_s),
        .full_o    (prio_full),
        .empty_o   (prio_empty_s),
        .head_o    (prio_head_s)
    );

    tx_queue_sync_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH),
        .PTR_WIDTH    (PTR_WIDTH)
    ) u_norm_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .wr_en_i   (norm_wr_en),
        .wr_data_i (norm_wr_data),
        .rd_en_i   (norm_pop_s),
        .full_o    (norm_full),
        .empty_o   (norm_empty_s),
        .head_o    (norm_head_s)
    );

    // Pop strobes: a grant only takes effect in IDLE and when its class has data.
    always_comb begin
        prio_pop_s = 1'b0;
        norm_pop_s = 1'b0;
        if (state_q == TXQ_IDLE) begin
            if (grant_priority && !prio_empty_s) begin
                prio_pop_s = 1'b1;
            end else if (grant_normal && !norm_empty_s) begin
                norm_pop_s = 1'b1;
            end else begin
                prio_pop_s = 1'b0;
                norm_pop_s = 1'b0;
            end
        end else begin
            prio_pop_s = 1'b0;
            norm_pop_s = 1'b0;
        end
    end

    // Control FSM with registered request, start pulse and data outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= TXQ_IDLE;
            class_q     <= TXQ_CLASS_PRIO;
            req_prio_q  <= 1'b0;
            req_norm_q  <= 1'b0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= {PACKET_WIDTH{1'b0}};
        end else begin
            case (state_q)
                TXQ_IDLE: begin
                    tx_enable_q <= 1'b0;
                    if (prio_pop_s) begin
                        tx_data_q   <= prio_head_s;
                        tx_enable_q <= 1'b1;
                        class_q     <= TXQ_CLASS_PRIO;
                        req_prio_q  <= 1'b1;
                        req_norm_q  <= 1'b0;
                        state_q     <= TXQ_SEND;
                    end else if (norm_pop_s) begin
                        tx_data_q   <= norm_head_s;
                        tx_enable_q <= 1'b1;
                        class_q     <= TXQ_CLASS_NORM;
                        req_prio_q  <= 1'b0;
                        req_norm_q  <= 1'b1;
                        state_q     <= TXQ_SEND;
                    end else begin
                        req_prio_q  <= ~prio_empty_s;
                        req_norm_q  <= ~norm_empty_s;
                    end
                end
                TXQ_SEND: begin
                    tx_enable_q <= 1'b0;
                    if (tx_done) begin
                        req_prio_q <= 1'b0;
                        req_norm_q <= 1'b0;
                        state_q    <= TXQ_RELEASE;
                    end else begin
                        req_prio_q <= (class_q == TXQ_CLASS_PRIO);
                        req_norm_q <= (class_q == TXQ_CLASS_NORM);
                    end
                end
                TXQ_RELEASE: begin
                    tx_enable_q <= 1'b0;
                    req_prio_q  <= 1'b0;
                    req_norm_q  <= 1'b0;
                    // Waiting for both grants low forces the arbiter back through NO_OUTPUT.
                    if (!grant_priority && !grant_normal) begin
                        state_q <= TXQ_IDLE;
                    end else begin
                        state_q <= TXQ_RELEASE;
                    end
                end
                default: begin
                    state_q     <= TXQ_IDLE;
                    req_prio_q  <= 1'b0;
                    req_norm_q  <= 1'b0;
                    tx_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_priority = req_prio_q;
    assign req_normal   = req_norm_q;
    assign tx_enable    = tx_enable_q;
    assign tx_data      = tx_data_q;

`ifdef TX_QUEUE_STATS_EN
    logic [15:0] prio_drop_q;
    logic [15:0] norm_drop_q;
    logic [15:0] sent_q;
    logic        prio_drop_s;
    logic        norm_drop_s;
    logic        sent_s;

    // Event strobes for the statistics counters.
    always_comb begin
        prio_drop_s = prio_wr_en & prio_full & ~prio_pop_s;
        norm_drop_s = norm_wr_en & norm_full & ~norm_pop_s;
        sent_s      = (state_q == TXQ_SEND) & tx_done;
    end

    // Saturating statistics counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_drop_q <= 16'd0;
            norm_drop_q <= 16'd0;
            sent_q      <= 16'd0;
        end else begin
            if (prio_drop_s) begin
                prio_drop_q <= txq_sat_inc16(prio_drop_q);
            end else begin
                prio_drop_q <= prio_drop_q;
            end
            if (norm_drop_s) begin
                norm_drop_q <= txq_sat_inc16(norm_drop_q);
            end else begin
                norm_drop_q <= norm_drop_q;
            end
            if (sent_s) begin
                sent_q <= txq_sat_inc16(sent_q);
            end else begin
                sent_q <= sent_q;
            end
        end
    end

    assign prio_drop_count = prio_drop_q;
    assign norm_drop_count = norm_drop_q;
    assign sent_count      = sent_q;
`endif

endmodule

// File: tb/tb_tx_queue.sv
// Directed bench for tx_queue with a behavioural arbiter and byte transmitter.
// Build with TX_QUEUE_STATS_EN defined to also check the statistics counters.
module tb_tx_queue;

    logic       clock = 1'b0;
    logic       reset;
    logic       prio_wr_en;
    logic [7:0] prio_wr_data;
    logic       prio_full;
    logic       norm_wr_en;
    logic [7:0] norm_wr_data;
    logic       norm_full;
    logic       req_priority;
    logic       req_normal;
    logic       grant_priority;
    logic       grant_normal;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_done;
`ifdef TX_QUEUE_STATS_EN
    logic [15:0] prio_drop_count;
    logic [15:0] norm_drop_count;
    logic [15:0] sent_count;
`endif

    logic       arb_hold;
    logic       man_done;
    logic       xmt_done;
    int         xmt_cnt;
    logic [7:0] sent_log [$];
    int         done_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    tx_queue dut (
        .clock          (clock),
        .reset          (reset),
        .prio_wr_en     (prio_wr_en),
        .prio_wr_data   (prio_wr_data),
        .prio_full      (prio_full),
        .norm_wr_en     (norm_wr_en),
        .norm_wr_data   (norm_wr_data),
        .norm_full      (norm_full),
        .req_priority   (req_priority),
        .req_normal     (req_normal),
        .grant_priority (grant_priority),
        .grant_normal   (grant_normal),
        .tx_enable      (tx_enable),
        .tx_data        (tx_data),
        .tx_done        (tx_done)
`ifdef TX_QUEUE_STATS_EN
       ,.prio_drop_count (prio_drop_count),
        .norm_drop_count (norm_drop_count),
        .sent_count      (sent_count)
`endif
    );

    always #5 clock = ~clock;

    assign tx_done = xmt_done | man_done;

    // Arbiter model: grant from NO_OUTPUT with priority first, hold while the request stays high.
    always @(posedge clock) begin
        if (reset || arb_hold) begin
            grant_priority <= 1'b0;
            grant_normal   <= 1'b0;
        end else if (!grant_priority && !grant_normal) begin
            grant_priority <= req_priority;
            grant_normal   <= !req_priority && req_normal;
        end else if (grant_priority && !req_priority) begin
            grant_priority <= 1'b0;
        end else if (grant_normal && !req_normal) begin
            grant_normal <= 1'b0;
        end
    end

    // Transmitter model: irq pulse a few cycles after each start pulse.
    always @(posedge clock) begin
        if (reset) begin
            xmt_cnt  <= 0;
            xmt_done <= 1'b0;
        end else begin
            xmt_done <= 1'b0;
            if (xmt_cnt != 0) begin
                xmt_cnt <= xmt_cnt - 1;
                if (xmt_cnt == 1) xmt_done <= 1'b1;
            end else if (tx_enable) begin
                xmt_cnt <= 3;
            end
        end
    end

    always @(negedge clock) begin
        if (tx_enable === 1'b1) sent_log.push_back(tx_data);
        if (tx_done === 1'b1) done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; prio_wr_en = 1'b0; norm_wr_en = 1'b0;
        prio_wr_data = 8'h00; norm_wr_data = 8'h00; arb_hold = 1'b0; man_done = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({prio_full, norm_full, req_priority, req_normal, tx_enable, tx_data} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", {prio_full, norm_full, req_priority, req_normal, tx_enable, tx_data}, 13'd0);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({req_priority, req_normal, tx_enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle_reqs: got %b want %b", {req_priority, req_normal, tx_enable}, 3'b000);
        end
`ifdef TX_QUEUE_STATS_EN
        n_checks++;
        if ({prio_drop_count, norm_drop_count, sent_count} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h want %h", {prio_drop_count, norm_drop_count, sent_count}, 48'd0);
        end
`endif
    endtask

    task automatic test_latency();
        int base;
        bit ok;
        base = sent_log.size();
        prio_wr_data = 8'hA5; prio_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0;
        n_checks++;
        if (req_priority !== 1'b0) begin
            n_fail++; $display("FAIL lat_req_cycle_n: got %b want %b", req_priority, 1'b0);
        end
        tick();
        n_checks++;
        if ({req_priority, tx_enable} !== 2'b10) begin
            n_fail++; $display("FAIL lat_req_n1: got %b want %b", {req_priority, tx_enable}, 2'b10);
        end
        tick();
        n_checks++;
        if ({grant_priority, tx_enable} !== 2'b10) begin
            n_fail++; $display("FAIL lat_grant_n2: got %b want %b", {grant_priority, tx_enable}, 2'b10);
        end
        tick();
        n_checks++;
        if ({tx_enable, tx_data} !== {1'b1, 8'hA5}) begin
            n_fail++; $display("FAIL lat_tx_n3: got %h want %h", {tx_enable, tx_data}, {1'b1, 8'hA5});
        end
        tick();
        n_checks++;
        if ({tx_enable, req_priority, req_normal} !== 3'b010) begin
            n_fail++; $display("FAIL lat_send_hold: got %b want %b", {tx_enable, req_priority, req_normal}, 3'b010);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (ok !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++; $display("FAIL lat_done_data: got done=%b data=%h want done=1 data=a5", ok, tx_data);
        end
        tick();
        n_checks++;
        if ({req_priority, req_normal} !== 2'b00) begin
            n_fail++; $display("FAIL lat_release_reqs: got %b want %b", {req_priority, req_normal}, 2'b00);
        end
        repeat (5) tick();
        n_checks++;
        if ({req_priority, req_normal, grant_priority, grant_normal, tx_enable} !== 5'b00000 ||
            sent_log.size() != base + 1) begin
            n_fail++;
            $display("FAIL lat_back_idle: got %b sent=%0d want %b sent=%0d",
                     {req_priority, req_normal, grant_priority, grant_normal, tx_enable},
                     sent_log.size() - base, 5'b00000, 1);
        end
    endtask

    task automatic test_order();
        int base;
        int target;
        bit ok;
        logic [23:0] got;
        base = sent_log.size();
        target = done_cnt + 3;
        norm_wr_data = 8'h11; norm_wr_en = 1'b1;
        prio_wr_data = 8'h33; prio_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0;
        norm_wr_data = 8'h22;
        tick();
        norm_wr_en = 1'b0;
        wait_done(target, ok);
        got = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            if (base + i < sent_log.size()) got = {got[15:0], sent_log[base + i]};
        end
        n_checks++;
        if (ok !== 1'b1 || sent_log.size() != base + 3) begin
            n_fail++; $display("FAIL order_count: got %0d sends want %0d", sent_log.size() - base, 3);
        end
        n_checks++;
        if (got !== 24'h331122) begin
            n_fail++; $display("FAIL order_sequence: got %h want %h", got, 24'h331122);
        end
    endtask

    task automatic test_preempt();
        int base;
        int target;
        bit ok;
        logic [23:0] got;
        base = sent_log.size();
        target = done_cnt + 3;
        norm_wr_data = 8'h01; norm_wr_en = 1'b1;
        tick();
        norm_wr_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (ok !== 1'b1 || tx_data !== 8'h01) begin
            n_fail++; $display("FAIL preempt_start: got en=%b data=%h want en=1 data=01", ok, tx_data);
        end
        prio_wr_data = 8'h02; prio_wr_en = 1'b1;
        norm_wr_data = 8'h03; norm_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0; norm_wr_en = 1'b0;
        tick();
        n_checks++;
        if ({req_priority, req_normal} !== 2'b01) begin
            n_fail++; $display("FAIL preempt_send_reqs: got %b want %b", {req_priority, req_normal}, 2'b01);
        end
        wait_done(target, ok);
        got = 24'h000000;
        for (int i = 0; i < 3; i++) begin
            if (base + i < sent_log.size()) got = {got[15:0], sent_log[base + i]};
        end
        n_checks++;
        if (ok !== 1'b1 || sent_log.size() != base + 3 || got !== 24'h010203) begin
            n_fail++; $display("FAIL preempt_sequence: got %h (%0d sends) want %h (3 sends)", got, sent_log.size() - base, 24'h010203);
        end
    endtask

    task automatic test_full();
        int base;
        int target;
        int bad;
        bit ok;
        base = sent_log.size();
        target = done_cnt + 8;
        arb_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prio_wr_data = 8'h80 | 8'(i); prio_wr_en = 1'b1;
            tick();
            if (i == 6) begin
                n_checks++;
                if (prio_full !== 1'b0) begin
                    n_fail++; $display("FAIL full_after7: got %b want %b", prio_full, 1'b0);
                end
            end
        end
        prio_wr_en = 1'b0;
        n_checks++;
        if (prio_full !== 1'b1) begin
            n_fail++; $display("FAIL full_after8: got %b want %b", prio_full, 1'b1);
        end
        prio_wr_data = 8'hFF; prio_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0;
        n_checks++;
        if ({prio_full, req_priority, grant_priority} !== 3'b110) begin
            n_fail++; $display("FAIL full_after9: got %b want %b", {prio_full, req_priority, grant_priority}, 3'b110);
        end
`ifdef TX_QUEUE_STATS_EN
        n_checks++;
        if (prio_drop_count !== 16'd1 || norm_drop_count !== 16'd0) begin
            n_fail++; $display("FAIL full_drop_count: got %0d/%0d want 1/0", prio_drop_count, norm_drop_count);
        end
`endif
        arb_hold = 1'b0;
        wait_done(target, ok);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (base + i >= sent_log.size() || sent_log[base + i] !== (8'h80 | 8'(i))) bad++;
        end
        n_checks++;
        if (ok !== 1'b1 || sent_log.size() != base + 8 || bad != 0 || prio_full !== 1'b0) begin
            n_fail++; $display("FAIL full_drain: got %0d sends %0d wrong full=%b want 8 sends 0 wrong full=0", sent_log.size() - base, bad, prio_full);
        end
    endtask

    task automatic test_wrap_full();
        int base;
        int target;
        int bad;
        bit ok;
        base = sent_log.size();
        target = done_cnt + 9;
        arb_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prio_wr_data = 8'h90 | 8'(i); prio_wr_en = 1'b1;
            tick();
        end
        prio_wr_en = 1'b0;
        tick();
        n_checks++;
        if ({prio_full, req_priority} !== 2'b11) begin
            n_fail++; $display("FAIL wrap_filled: got %b want %b", {prio_full, req_priority}, 2'b11);
        end
        arb_hold = 1'b0;
        tick();
        prio_wr_data = 8'h98; prio_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0;
        n_checks++;
        if ({prio_full, tx_enable, tx_data} !== {1'b1, 1'b1, 8'h90}) begin
            n_fail++; $display("FAIL wrap_push_pop: got %h want %h", {prio_full, tx_enable, tx_data}, {1'b1, 1'b1, 8'h90});
        end
        wait_done(target, ok);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (base + i >= sent_log.size() || sent_log[base + i] !== (8'h90 + 8'(i))) bad++;
        end
        n_checks++;
        if (ok !== 1'b1 || sent_log.size() != base + 9 || bad != 0) begin
            n_fail++; $display("FAIL wrap_order: got %0d sends %0d wrong want 9 sends 0 wrong", sent_log.size() - base, bad);
        end
`ifdef TX_QUEUE_STATS_EN
        n_checks++;
        if (prio_drop_count !== 16'd1 || sent_count !== 16'd24) begin
            n_fail++; $display("FAIL wrap_stats: got drop=%0d sent=%0d want drop=1 sent=24", prio_drop_count, sent_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        base = sent_log.size();
        prio_wr_data = 8'h5A; prio_wr_en = 1'b1;
        norm_wr_data = 8'h6B; norm_wr_en = 1'b1;
        tick();
        prio_wr_en = 1'b0; norm_wr_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        n_checks++;
        if (ok !== 1'b1 || req_priority !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_in_send: got start=%b req=%b want 1/1", ok, req_priority);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({prio_full, norm_full, req_priority, req_normal, tx_enable, tx_data} !== 13'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b want %b", {prio_full, norm_full, req_priority, req_normal, tx_enable, tx_data}, 13'd0);
        end
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (6) tick();
        n_checks++;
        if ({req_priority, req_normal, tx_enable, grant_priority, grant_normal} !== 5'b00000 ||
            sent_log.size() != base + 1) begin
            n_fail++;
            $display("FAIL rstmid_discarded: got %b sends=%0d want %b sends=1",
                     {req_priority, req_normal, tx_enable, grant_priority, grant_normal}, sent_log.size() - base, 5'b00000);
        end
`ifdef TX_QUEUE_STATS_EN
        n_checks++;
        if (sent_count !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_sent_count: got %0d want %0d", sent_count, 0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_order();
        test_preempt();
        test_full();
        test_wrap_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
